// File: rtl/word_to_ascii_stream.sv
// word_to_ascii_stream: streams a WIDTH-bit word as 7-bit ASCII characters,
// MSB-first, one character per out_valid/out_ready handshake, in binary
// ('0'/'1') or hex ('0'-'9','A'-'F') mode selected per word.
// Optional build macro WORD_TO_ASCII_PREFIX_EN prepends "0b"/"0x" to each word.
module word_to_ascii_stream #(
  parameter int WIDTH = 16,
  parameter int CW    = ($clog2(WIDTH + 2) < 1) ? 1 : $clog2(WIDTH + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_hex,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [6:0]       out_char,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [CW-1:0]    out_col,
  output logic             busy
);

  localparam int NB = WIDTH;
  localparam int NH = (WIDTH + 3) / 4;
`ifdef WORD_TO_ASCII_PREFIX_EN
  localparam int PFX = 2;
`else
  localparam int PFX = 0;
`endif
  // Column of the final digit; kept instead of the total so it always fits in CW bits.
  localparam logic [CW-1:0] LC_B = CW'(NB - 1 + PFX);
  localparam logic [CW-1:0] LC_H = CW'(NH - 1 + PFX);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t          state;
  logic [WIDTH-1:0] data_q;
  logic            hex_q;
  logic [CW-1:0]   last_col;
  logic [CW-1:0]   nxt_col;
  logic [CW-1:0]   first_last;

  // Character for string column col of word w in mode hx.
  function automatic logic [6:0] char_at(input logic [CW-1:0] col,
                                         input logic [WIDTH-1:0] w,
                                         input logic hx);
    logic [4*NH-1:0] pw;
    logic [3:0]      nib;
    logic            b;
    int              d;
    pw = '0;
    pw[WIDTH-1:0] = w;            // top nibble zero-extended
    d   = int'(col) - PFX;        // digit index, 0 = most significant
    nib = 4'(pw >> (4 * (NH - 1 - d)));
    b   = 1'(w >> (NB - 1 - d));
    if (hx)
      char_at = (nib < 4'd10) ? 7'd48 + {3'b0, nib} : 7'd55 + {3'b0, nib};
    else
      char_at = 7'd48 + {6'b0, b};
`ifdef WORD_TO_ASCII_PREFIX_EN
    if (col == '0)
      char_at = 7'd48;
    else if (col == CW'(1))
      char_at = hx ? 7'd120 : 7'd98;
`endif
  endfunction

  assign nxt_col    = out_col + {{(CW-1){1'b0}}, 1'b1};
  assign first_last = in_hex ? LC_H : LC_B;

  // Accept only from IDLE and never while reset is held.
  assign in_ready = (state == IDLE) && !rst;

  // Control FSM with registered character outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      data_q    <= '0;
      hex_q     <= 1'b0;
      last_col  <= '0;
      out_col   <= '0;
      out_char  <= 7'd0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_q    <= in_data;
            hex_q     <= in_hex;
            last_col  <= first_last;
            out_col   <= '0;
            out_char  <= char_at('0, in_data, in_hex);
            out_last  <= (first_last == '0);
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (out_last) begin
              out_col   <= '0;
              out_char  <= 7'd0;
              out_last  <= 1'b0;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              out_col  <= nxt_col;
              out_char <= char_at(nxt_col, data_q, hex_q);
              out_last <= (nxt_col == last_col);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/word_to_ascii_stream.md
Name: word_to_ascii_stream

Overview:
- Parametrised successor to the single-bit binary-to-ASCII converter.
- Takes a WIDTH-bit word and streams its printable representation, one 7-bit ASCII character per handshake, MSB-first.
- Runtime-selectable binary ('0'/'1') or hexadecimal ('0'-'9', 'A'-'F') mode.
- Sits between the datapath debug taps (PC, register, ALU result) and the text display / UART character sink.

Parameters:
- WIDTH, 16, bit width of the input word; minimum 1.
- CW, $clog2(WIDTH+2) (minimum 1), width of the character counter and out_col; derived, not overridden.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-high reset.
- in_data, input, WIDTH, word to convert.
- in_hex, input, 1, mode: 0 = binary, 1 = hex; sampled with in_data.
- in_valid, input, 1, in_data/in_hex valid.
- in_ready, output, 1, block can accept a word.
- out_char, output, 7, current ASCII character.
- out_valid, output, 1, out_char valid.
- out_ready, input, 1, sink accepts out_char.
- out_last, output, 1, out_char is the final character of the word.
- out_col, output, CW, 0-based position of out_char in the emitted string.
- busy, output, 1, high while a word is being emitted.

Behaviour:
- Reset values (one edge with rst=1, regardless of in-flight word): state IDLE, out_valid 0, out_char 7'd0, out_last 0, out_col 0, busy 0, latched word/mode cleared. in_ready is 0 while rst=1.
- States are IDLE and EMIT.
- Digit counts:
  - Binary: NB = WIDTH characters.
  - Hex: NH = ceil(WIDTH/4) characters; the top nibble is zero-extended when WIDTH is not a multiple of 4.
- IDLE:
  - in_ready = 1; out_valid = 0.
  - On in_valid & in_ready: latch in_data and in_hex, load total = NB or NH, set out_col = 0, go EMIT.
- EMIT:
  - out_valid = 1; busy = 1; in_ready = 0.
  - out_char = 48 + bit for binary digits. Hex digits: 48 + nibble for nibble < 10, 55 + nibble for 10..15.
  - The digit at position out_col is bit/nibble index (N-1-out_col), so MSB is first.
  - out_last = (out_col == total-1).
  - On out_valid & out_ready: if out_last, go IDLE; else out_col increments.
- Latency and throughput:
  - The first character is valid the cycle after input acceptance.
  - Zero-backpressure throughput is one character per cycle, plus one IDLE cycle between words.
  - in_ready never asserts during EMIT; no overlap.
- Backpressure: while out_valid & !out_ready, out_char, out_col and out_last hold stable.
- Input side: changes to in_data/in_hex during EMIT have no effect on the current word.
- Arithmetic: character addition is 7-bit unsigned; out_col never exceeds total-1 and never wraps.
- Boundary cases:
  - WIDTH=1: binary emits 1 char; hex emits 1 char ('0' or '1').
  - Accept on the cycle rst=1 is impossible, since in_ready=0.
  - rst during EMIT: the word is dropped, no out_last is produced, and the block returns to IDLE.

Optional Feature:
- Macro: WORD_TO_ASCII_PREFIX_EN.
- When defined:
  - Each word is preceded by two characters: '0' (48), then 'b' (98) in binary mode or 'x' (120) in hex mode.
  - total = digits + 2, and out_col counts the prefix (digits start at out_col = 2).
  - out_last still marks only the final digit.
  - Handshake and backpressure rules apply to prefix characters unchanged.
- When undefined: no prefix; behaviour exactly as above.

Test Plan:
- WIDTH=8, in_data=8'hA5, in_hex=0, out_ready=1 -> out_char sequence 49,48,49,48,48,49,48,49; out_col 0..7; out_last only on the 8th; in_ready returns 1 the cycle after.
- WIDTH=8, in_data=8'hA5, in_hex=1 -> 65 ('A'), 53 ('5'); out_last on the 2nd.
- WIDTH=10, in_data=10'h3FF, in_hex=1 -> 51,70,70 ("3FF").
- WIDTH=8, hex 8'h0F with out_ready low for 3 cycles at out_col=1 -> out_char stays 70, out_col 1, out_last 1 throughout; completes on the first out_ready=1.
- WIDTH=16, binary word accepted, rst=1 at out_col=5 -> next cycle out_valid=0, busy=0, out_col=0; after rst drops in_ready=1; a new word 16'h0001 emits 15×48 then 49.
- With WORD_TO_ASCII_PREFIX_EN, WIDTH=8, hex 8'h3C -> 48,120,51,67; out_col 0..3; out_last on 67.
